// File: rtl/layer_pkg.sv
// Shared definitions for the layer-4 stream blocks: default geometry, the packer
// FSM state type and a width helper for position/channel counters.
package layer_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 32;
  localparam int DEFAULT_NUM_CHANNELS = 32;
  localparam int DEFAULT_IMG_SIZE     = 104;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order col/row position counter with wrap and a last-pixel flag; shared
// by the layer-4 packer and the output-side unpacker.
module raster_counter
  import layer_pkg::*;
#(
  parameter int IMG_SIZE = DEFAULT_IMG_SIZE
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        clear,
  input  logic                        advance,
  output logic [clog2(IMG_SIZE)-1:0]  row,
  output logic [clog2(IMG_SIZE)-1:0]  col,
  output logic                        last
);

  localparam int POS_W = clog2(IMG_SIZE);
  localparam logic [POS_W-1:0] MAX_POS = POS_W'(IMG_SIZE - 1);

  // NOTE: registers use non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == MAX_POS) begin
        col <= '0;
        row <= (row == MAX_POS) ? '0 : row + POS_W'(1);
      end else begin
        col <= col + POS_W'(1);
      end
    end
  end

  assign last = (row == MAX_POS) && (col == MAX_POS);

endmodule

// File: rtl/layer_4_pixel_packer.sv
// Packs NUM_CHANNELS serial channel values into one pixel word in raster order.
// Optional macro LAYER4_PACKER_DROP_CNT_EN adds a saturating drop_cnt output.
module layer_4_pixel_packer
  import layer_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int NUM_CHANNELS = DEFAULT_NUM_CHANNELS,
  parameter int IMG_SIZE     = DEFAULT_IMG_SIZE
) (
  input  logic                               Clk,
  input  logic                               Rst,
  input  logic                               start,
  input  logic [DATA_WIDTH-1:0]              ch_data,
  input  logic                               ch_valid,
  output logic                               ch_ready,
  output logic [DATA_WIDTH*NUM_CHANNELS-1:0] data_out,
  output logic                               valid_out,
  output logic [clog2(IMG_SIZE)-1:0]         row,
  output logic [clog2(IMG_SIZE)-1:0]         col,
  output logic                               frame_done
`ifdef LAYER4_PACKER_DROP_CNT_EN
  ,
  output logic [15:0]                        drop_cnt
`endif
);

  localparam int POS_W = clog2(IMG_SIZE);
  localparam int CH_W  = clog2(NUM_CHANNELS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

  state_t                  state, state_nxt;
  logic [CH_W-1:0]         ch_cnt;
  logic [DATA_WIDTH-1:0]   shadow [NUM_CHANNELS];
  logic                    arm, accept, pixel_done, last_pixel;
  logic [POS_W-1:0]        cur_row, cur_col;

  assign ch_ready   = (state == STREAM);
  assign arm        = (state == IDLE) && start;
  assign accept     = ch_valid && ch_ready;
  assign pixel_done = accept && (ch_cnt == LAST_CH);

  always_comb begin
    // NOTE: default assignment first keeps this always_comb free of latches.
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (pixel_done && last_pixel) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      ch_cnt     <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      row        <= '0;
      col        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      valid_out  <= pixel_done;
      frame_done <= (state == DONE);
      if (arm) begin
        ch_cnt <= '0;
      end else if (accept) begin
        ch_cnt <= pixel_done ? '0 : ch_cnt + CH_W'(1);
      end
      // The final channel bypasses the shadow and goes straight into data_out.
      if (pixel_done) begin
        for (int k = 0; k < NUM_CHANNELS - 1; k++) begin
          data_out[k*DATA_WIDTH +: DATA_WIDTH] <= shadow[k];
        end
        data_out[(NUM_CHANNELS-1)*DATA_WIDTH +: DATA_WIDTH] <= ch_data;
        row <= cur_row;
        col <= cur_col;
      end
    end
  end

  // NOTE: the shadow is pure datapath and is fully rewritten before every use,
  // so it is deliberately left without reset.
  always_ff @(posedge Clk) begin
    if (accept) shadow[ch_cnt] <= ch_data;
  end

  raster_counter #(
    .IMG_SIZE (IMG_SIZE)
  ) u_raster (
    .Clk     (Clk),
    .Rst     (Rst),
    .clear   (arm),
    .advance (pixel_done),
    .row     (cur_row),
    .col     (cur_col),
    .last    (last_pixel)
  );

`ifdef LAYER4_PACKER_DROP_CNT_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      drop_cnt <= '0;
    end else if (ch_valid && !ch_ready && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/layer_4_pixel_packer.md
Name: layer_4_pixel_packer

Overview:
Producer side of the layer-4 feature-map input stream. Accepts one DATA_WIDTH channel value per cycle from the upstream layer/buffer and packs NUM_CHANNELS consecutive values into one wide pixel word. Emits pixels in raster order with a one-cycle valid pulse, which is the data_in/valid_in interface consumed by the layer_4_featuremap_* convolution banks. Frames IMG_SIZE x IMG_SIZE pixels and reports row/column position and frame completion.

Parameters:
DATA_WIDTH, 32, width of one channel value (IEEE-754 single).
NUM_CHANNELS, 32, channels packed per pixel word.
IMG_SIZE, 104, feature-map width and height in pixels.

Ports:
Clk  in  1  clock.
Rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; arms a new frame when IDLE.
ch_data  in  DATA_WIDTH  channel value, channel 0 first.
ch_valid  in  1  ch_data valid.
ch_ready  out  1  packer accepts ch_data this cycle.
data_out  out  DATA_WIDTH*NUM_CHANNELS  packed pixel; channel k in bits [k*DATA_WIDTH +: DATA_WIDTH].
valid_out  out  1  one-cycle pulse, data_out holds a new pixel.
row  out  clog2(IMG_SIZE)  row of the pixel on data_out.
col  out  clog2(IMG_SIZE)  column of the pixel on data_out.
frame_done  out  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; data_out=0, valid_out=0, ch_ready=0, row=0, col=0, frame_done=0; all internal counters 0. Reset mid-frame discards the partial pixel and frame. No flush is performed.
- FSM states: IDLE, STREAM, DONE.
  - IDLE: ch_ready=0. A start pulse moves the FSM to STREAM and clears the channel, col and row counters.
  - STREAM: ch_ready=1. Each ch_valid&ch_ready handshake writes ch_data into slot ch_cnt of the shadow register and increments ch_cnt.
  - When ch_cnt==NUM_CHANNELS-1 is accepted: ch_cnt wraps to 0; the shadow register plus the final value load data_out; row/col outputs take the current pixel position; valid_out=1 on the next cycle.
  - After the pixel at row=IMG_SIZE-1, col=IMG_SIZE-1 completes, the FSM goes to DONE.
  - DONE: lasts one cycle; frame_done=1 and ch_ready=0; then returns to IDLE.
- Latency: the last channel of a pixel is accepted at cycle N; data_out and valid_out update at N+1. Back-to-back throughput is one pixel per NUM_CHANNELS cycles.
- No downstream backpressure. valid_out is a strict one-cycle pulse. data_out, row and col hold their values until the next pixel completes.
- Position counters: col increments per completed pixel and wraps at IMG_SIZE-1 to 0, incrementing row. The first pixel reports row=0, col=0.
- start while in STREAM or DONE is ignored. start coincident with Rst: reset wins.
- ch_valid while ch_ready=0: the data is dropped, with no state change.
- Gaps in ch_valid stall the packing only; the partial pixel is retained indefinitely.

Optional Feature:
- Macro LAYER4_PACKER_DROP_CNT_EN.
- Defined: adds output drop_cnt (16 bits). It increments on every cycle with ch_valid=1 and ch_ready=0, saturates at 16'hFFFF, is cleared by Rst only, and is not cleared by start.
- Undefined: no port and no logic; drops are silent.

Decomposition:
- Shared package layer_pkg: DATA_WIDTH, NUM_CHANNELS, IMG_SIZE defaults; the FSM state enum (IDLE/STREAM/DONE); a clog2 helper function for counter widths.
- One natural sub-module, raster_counter, holding the col/row counter with wrap and last-pixel flag. It is reused by the future output-side unpacker.

Test Plan:
- Overrides NUM_CHANNELS=4, IMG_SIZE=2; start, then 16 contiguous values 1..16 -> four valid_out pulses, 4 cycles apart. First pulse: data_out={4,3,2,1}, row=0, col=0. Last pulse: {16,15,14,13}, row=1, col=1. frame_done fires 1 cycle after the last pulse, then ch_ready=0.
- ch_valid toggled 1/0 every cycle for one pixel -> valid_out 1 cycle after the 4th accepted value; packed order unchanged.
- Rst asserted after 2 of 4 channels, then start plus values 9..12 -> first pixel {12,11,10,9}; no stale data from before reset.
- ch_valid=1 for 5 cycles in IDLE with no start -> no valid_out, counters remain 0. With LAYER4_PACKER_DROP_CNT_EN, drop_cnt=5.
- start pulsed mid-frame at pixel 1 -> ignored; frame still completes after 4 pixels with a single frame_done.
- Default parameters, 104*104*32 values -> exactly 10816 valid_out pulses; final row=103, col=103; one frame_done.
